// File: rtl/tbird_state_ctrl_pkg.sv
// Shared definitions for the tail-light control stage: state encodings,
// switch bit positions and the request-decode helper.
package tbird_state_ctrl_pkg;

    // Light state encodings seen by the output stage
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LEFT   = 4'd1;
    localparam logic [3:0] RIGHT  = 4'd2;
    localparam logic [3:0] HAZARD = 4'd3;

    // Switch bit positions within SW[3:0]
    localparam int SW_LEFT   = 0;
    localparam int SW_RIGHT  = 1;
    localparam int SW_BRAKE  = 2;
    localparam int SW_HAZARD = 3;

    // Priority decode of the debounced switches into a requested light state.
    // Left and right together are treated as a hazard request.
    function automatic logic [3:0] decode_request(input logic [3:0] db);
        logic [3:0] req;
        if (db[SW_HAZARD] || (db[SW_LEFT] && db[SW_RIGHT])) begin
            req = HAZARD;
        end else if (db[SW_LEFT]) begin
            req = LEFT;
        end else if (db[SW_RIGHT]) begin
            req = RIGHT;
        end else begin
            req = IDLE;
        end
        return req;
    endfunction

    // Only the low four encodings are meaningful; anything else is corrupt state
    function automatic logic state_legal(input logic [3:0] s);
        return (s[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/tbird_state_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter. A bit's
// debounced value only follows its synchronised input after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Bring the asynchronous switch levels into the clock domain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic [CW-1:0] cnt_r;
        logic          stable_r;

        // Count consecutive disagreeing cycles; accept the new level on the last one
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_r    <= '0;
                stable_r <= 1'b0;
            end else if (sync_r[g] == stable_r) begin
                cnt_r    <= '0;
                stable_r <= stable_r;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r    <= '0;
                stable_r <= sync_r[g];
            end else begin
                cnt_r    <= cnt_r + CW'(1);
                stable_r <= stable_r;
            end
        end

        assign stable[g] = stable_r;
    end

endmodule

// File: rtl/tbird_state_ctrl.sv
// Upstream control for the tail lights: debounced switches, blink clock
// generation, a local copy of the animation step and the light-state FSM.
// State changes are lined up with the animation so a new pattern always
// begins at step 0; only a hazard request may cut an animation short.
module tbird_state_ctrl
    import tbird_state_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int BLINK_HZ        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [9:0] SW,
    output logic [3:0] cur,
    output logic       slow_clock,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int            HALF     = CLK_HZ / (2 * BLINK_HZ);
    localparam int            DW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

    logic [3:0]    db_s;
    logic [3:0]    req_s;
    logic [3:0]    next_cur_s;
    logic          wrap_s;
    logic          rise_s;
    logic          unused_s;

    logic [DW-1:0] div_cnt_r;
    logic          slow_clock_r;
    logic          tick_r;
    logic [1:0]    phase_r;
    logic [3:0]    cur_r;

    sw_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (SW[3:0]),
        .stable  (db_s)
    );

    // Upper switches and the brake bit play no part in state decisions
    assign unused_s = ^{SW[9:4], db_s[SW_BRAKE]};

    // The edge that raises slow_clock is the one every step-aligned update uses
    assign wrap_s = (div_cnt_r == DIV_LAST);
    assign rise_s = wrap_s & ~slow_clock_r;

    // Half-period divider producing the 50% duty blink clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r    <= '0;
            slow_clock_r <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r    <= '0;
            slow_clock_r <= ~slow_clock_r;
        end else begin
            div_cnt_r    <= div_cnt_r + DW'(1);
            slow_clock_r <= slow_clock_r;
        end
    end

    // Tick marks the cycle in which slow_clock has just gone high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= rise_s;
        end
    end

    // Mirror of the output stage's 2-bit counter, which advances on slow_clock rising
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= 2'd0;
        end else if (rise_s) begin
            phase_r <= phase_r + 2'd1;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Decide the next light state; the request uses the pre-edge debounced bits
    always_comb begin
        req_s      = decode_request(db_s);
        next_cur_s = cur_r;
        if (rise_s) begin
            if (!state_legal(cur_r)) begin
                next_cur_s = IDLE;
            end else if ((req_s == HAZARD) && (cur_r != HAZARD)) begin
                next_cur_s = HAZARD;
            end else if ((req_s != cur_r) && (phase_r == 2'd3)) begin
                next_cur_s = req_s;
            end else begin
                next_cur_s = cur_r;
            end
        end else begin
            next_cur_s = cur_r;
        end
    end

    // Light-state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_r <= IDLE;
        end else begin
            cur_r <= next_cur_s;
        end
    end

    assign cur        = cur_r;
    assign slow_clock = slow_clock_r;
    assign tick       = tick_r;
    assign phase      = phase_r;

endmodule
